// File: rtl/regs_hazard_stall.sv
// -----------------------------------------------------------------------------
// regs_hazard_stall
//
// Issue-side register interlock between decode and execute. Each architectural
// register owns a 3-bit pending-write countdown. Decode stalls while any source
// it actually reads has a nonzero countdown. An issued write arms the
// destination's countdown with LATENCY. Writeback may clear a countdown early.
// Register 0 is hard-wired idle: never busy, never stalls, writes ignored.
//
// Parameters
//   WIDTH    number of architectural registers (index width = $clog2(WIDTH))
//   LATENCY  cycles from issue until a written register is readable (1..7)
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   dec_valid     decode holds a valid instruction
//   rnum1/rnum2   source register numbers
//   use_r1/use_r2 the corresponding source is actually read
//   wnum          destination register number
//   is_write_reg  instruction writes wnum
//   wb_valid      writeback completes this cycle
//   wb_num        register written back
//   dec_ready     instruction can be accepted (combinational, !hazard)
//   stall         decode must hold (combinational, dec_valid & hazard)
//   stall_start   registered one-cycle pulse after entry into STALL
//   busy_mask     bit i set while countdown i is nonzero
//   stall_cycles  (only with HAZARD_STALL_CNT_EN) saturating count of cycles
//                 with stall high, cleared only by reset
//
// Build option: define HAZARD_STALL_CNT_EN to add the stall_cycles counter.
// -----------------------------------------------------------------------------
module regs_hazard_stall #(
  parameter  int WIDTH      = 32,
  parameter  int LATENCY    = 3,
  localparam int ADDR_WIDTH = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_valid,
  input  logic [ADDR_WIDTH-1:0] rnum1,
  input  logic [ADDR_WIDTH-1:0] rnum2,
  input  logic                  use_r1,
  input  logic                  use_r2,
  input  logic [ADDR_WIDTH-1:0] wnum,
  input  logic                  is_write_reg,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_num,
  output logic                  dec_ready,
  output logic                  stall,
  output logic                  stall_start,
  output logic [WIDTH-1:0]      busy_mask
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cycles
`endif
);

  localparam logic [2:0] LAT3 = 3'(LATENCY);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  logic [2:0] cnt_q [WIDTH];
  logic [2:0] cnt_d [WIDTH];
  logic       hazard;
  logic       issue;
  state_e     state_q, state_d;
  logic       stall_start_q, stall_start_d;

  // Sources are checked against the pre-issue counters only, so an
  // instruction whose destination equals one of its sources never blocks
  // itself on its own write.
  always_comb begin
    hazard = (use_r1 && (cnt_q[rnum1] != 3'd0)) ||
             (use_r2 && (cnt_q[rnum2] != 3'd0));
  end

  assign issue     = dec_valid && !hazard;
  assign dec_ready = !hazard;
  assign stall     = dec_valid && hazard;

  // Per-register next state. Later assignments override earlier ones, giving
  // the priority issue-set > writeback-clear > decrement.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      // NOTE: every combinational output gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      cnt_d[i] = cnt_q[i];
      if (cnt_q[i] != 3'd0) begin
        cnt_d[i] = cnt_q[i] - 3'd1;
      end
      if (wb_valid && (wb_num == ADDR_WIDTH'(i))) begin
        cnt_d[i] = 3'd0;
      end
      if (issue && is_write_reg && (wnum == ADDR_WIDTH'(i))) begin
        cnt_d[i] = LAT3;
      end
    end
    // Register 0 is never busy.
    cnt_d[0] = 3'd0;
  end

  // NOTE: the countdown array is reset, not left to power-up garbage: a
  // spurious nonzero entry would stall decode on a register nobody wrote.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= 3'd0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values regardless of process ordering.
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      busy_mask[i] = (cnt_q[i] != 3'd0);
    end
  end

  // FSM: state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RUN;
      stall_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      stall_start_q <= stall_start_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (stall)  state_d = STALL;
      STALL:   if (!stall) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // FSM: outputs. The pulse is computed on the RUN->STALL transition and
  // registered, so it appears in the cycle after the edge.
  always_comb begin
    stall_start_d = (state_q == RUN) && (state_d == STALL);
  end

  assign stall_start = stall_start_q;

`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] stall_cycles_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= 16'd0;
    end else if (stall && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_q <= stall_cycles_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_regs_hazard_stall.sv
// -----------------------------------------------------------------------------
// tb_regs_hazard_stall
//
// Self-checking bench for regs_hazard_stall. A behavioural model of the
// per-register countdowns and the RUN/STALL FSM produces the expected outputs
// for every cycle; they are queued when stimulus is applied and popped and
// compared when the DUT outputs are sampled on the falling edge. Directed
// scenarios add explicit length/count checks. Define HAZARD_STALL_CNT_EN for
// the stall_cycles counter checks.
// -----------------------------------------------------------------------------
module tb_regs_hazard_stall;

  localparam int WIDTH   = 32;
  localparam int LATENCY = 3;
  localparam int AW      = $clog2(WIDTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          dec_valid;
  logic [AW-1:0] rnum1, rnum2, wnum, wb_num;
  logic          use_r1, use_r2, is_write_reg, wb_valid;
  logic          dec_ready, stall, stall_start;
  logic [WIDTH-1:0] busy_mask;
`ifdef HAZARD_STALL_CNT_EN
  logic [15:0]   stall_cycles;
`endif

  regs_hazard_stall #(.WIDTH(WIDTH), .LATENCY(LATENCY)) dut (
    .clk          (clk),
    .rst          (rst),
    .dec_valid    (dec_valid),
    .rnum1        (rnum1),
    .rnum2        (rnum2),
    .use_r1       (use_r1),
    .use_r2       (use_r2),
    .wnum         (wnum),
    .is_write_reg (is_write_reg),
    .wb_valid     (wb_valid),
    .wb_num       (wb_num),
    .dec_ready    (dec_ready),
    .stall        (stall),
    .stall_start  (stall_start),
    .busy_mask    (busy_mask)
`ifdef HAZARD_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  int mcnt [WIDTH];
  bit m_stalled;
  bit m_start;
  int m_scyc;

  typedef struct {
    logic             stall;
    logic             rdy;
    logic             start;
    logic [WIDTH-1:0] busy;
    logic [15:0]      scyc;
  } exp_t;

  exp_t sb [$];

  logic             last_stall, last_rdy, last_start;
  logic [WIDTH-1:0] last_busy;

  function automatic bit model_hazard();
    return (use_r1 && mcnt[rnum1] != 0) || (use_r2 && mcnt[rnum2] != 0);
  endfunction

  task automatic model_reset();
    foreach (mcnt[i]) mcnt[i] = 0;
    m_stalled = 0;
    m_start   = 0;
    m_scyc    = 0;
  endtask

  task automatic model_clock();
    bit h, iss, stl;
    h   = model_hazard();
    stl = dec_valid && h;
    iss = dec_valid && !h;
    for (int i = 1; i < WIDTH; i++) begin
      if (iss && is_write_reg && wnum == AW'(i))      mcnt[i] = LATENCY;
      else if (wb_valid && wb_num == AW'(i))          mcnt[i] = 0;
      else if (mcnt[i] > 0)                           mcnt[i] = mcnt[i] - 1;
    end
    m_start   = stl && !m_stalled;
    m_stalled = stl;
    if (stl && m_scyc < 65535) m_scyc++;
  endtask

  // One cycle: inputs are already applied (just after a rising edge).
  task automatic step(input string tag);
    exp_t e;
    e.stall = dec_valid && model_hazard();
    e.rdy   = !model_hazard();
    e.start = m_start;
    for (int i = 0; i < WIDTH; i++) e.busy[i] = (mcnt[i] != 0);
    e.scyc  = 16'(m_scyc);
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    last_stall = stall;
    last_rdy   = dec_ready;
    last_start = stall_start;
    last_busy  = busy_mask;
    check({tag, ".stall"},     32'(stall),       32'(e.stall));
    check({tag, ".dec_ready"}, 32'(dec_ready),   32'(e.rdy));
    check({tag, ".stall_start"}, 32'(stall_start), 32'(e.start));
    check({tag, ".busy_mask"}, busy_mask,        e.busy);
`ifdef HAZARD_STALL_CNT_EN
    check({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(e.scyc));
`endif
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic set_idle();
    dec_valid = 0; rnum1 = '0; rnum2 = '0; use_r1 = 0; use_r2 = 0;
    wnum = '0; is_write_reg = 0; wb_valid = 0; wb_num = '0;
  endtask

  task automatic set_write(input int r);
    set_idle();
    dec_valid = 1; wnum = AW'(r); is_write_reg = 1;
  endtask

  task automatic set_read1(input int r);
    set_idle();
    dec_valid = 1; rnum1 = AW'(r); use_r1 = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    model_reset();
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
  endtask

  // Writer of r5 followed directly by a reader of r5. Returns the number of
  // stalled cycles and the number of stall_start pulses up to acceptance.
  task automatic run_dep(input bit use_wb, input string tag, output int n, output int starts);
    set_write(5);
    step({tag, ".wr"});
    set_read1(5);
    if (use_wb) begin
      wb_valid = 1;
      wb_num   = AW'(5);
    end
    n = 0;
    starts = 0;
    for (int k = 0; k < 12; k++) begin
      step({tag, ".rd"});
      wb_valid = 0;
      n += int'(last_stall);
      starts += int'(last_start);
      if (!last_stall) break;
    end
    set_idle();
    step({tag, ".idle"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, starts, busy4;
    set_idle();
    rst = 0;
    model_reset();
    #2;
    check("reset.busy_mask", busy_mask, 0);
    check("reset.dec_ready", 32'(dec_ready), 1);
    check("reset.stall_start", 32'(stall_start), 0);
    do_reset();

    // Dependent read directly behind a writer: LATENCY stall cycles.
    run_dep(0, "dep", n, starts);
    check("dep.stall_len", n, LATENCY);
    check("dep.start_pulses", starts, 1);

    // Writeback on the first stall cycle: one stall cycle only.
    run_dep(1, "depwb", n, starts);
    check("depwb.stall_len", n, 1);
    check("depwb.start_pulses", starts, 1);

    // Register 0 is never busy.
    set_write(0);
    step("r0.wr");
    set_read1(0);
    step("r0.rd");
    check("r0.no_stall", 32'(last_stall), 0);
    check("r0.busy0", 32'(last_busy[0]), 0);

    // Unused source is ignored; issue-set beats writeback on the same register.
    set_write(7);
    step("r7.wr");
    set_idle();
    dec_valid = 1; rnum1 = AW'(7); use_r1 = 0;
    wnum = AW'(4); is_write_reg = 1; wb_valid = 1; wb_num = AW'(4);
    step("r7.rd");
    check("r7.no_stall", 32'(last_stall), 0);
    set_idle();
    busy4 = 0;
    for (int k = 0; k < 6; k++) begin
      step("r4.drain");
      busy4 += int'(last_busy[4]);
    end
    check("r4.busy_cycles", busy4, LATENCY);

    // Second source path and destination equal to source.
    set_write(9);
    step("r9.wr");
    set_idle();
    dec_valid = 1; rnum2 = AW'(9); use_r2 = 1;
    step("r9.rd2");
    check("r9.stall_r2", 32'(last_stall), 1);
    set_idle();
    repeat (4) step("r9.drain");
    set_idle();
    dec_valid = 1; rnum1 = AW'(11); use_r1 = 1; wnum = AW'(11); is_write_reg = 1;
    step("r11.self");
    check("r11.self_no_stall", 32'(last_stall), 0);
    set_idle();
    step("r11.busy");
    check("r11.busy", 32'(last_busy[11]), 1);
    repeat (3) step("r11.drain");

    // Randomised traffic on a small register range, checked by the model.
    for (int k = 0; k < 300; k++) begin
      dec_valid    = 1'($urandom_range(0, 1));
      rnum1        = AW'($urandom_range(0, 7));
      rnum2        = AW'($urandom_range(0, 7));
      use_r1       = 1'($urandom_range(0, 1));
      use_r2       = 1'($urandom_range(0, 1));
      wnum         = AW'($urandom_range(0, 7));
      is_write_reg = 1'($urandom_range(0, 1));
      wb_valid     = ($urandom_range(0, 3) == 0);
      wb_num       = AW'($urandom_range(0, 7));
      step("rand");
    end

    // Asynchronous reset mid-stall with cnt[5]=2.
    set_idle();
    repeat (8) step("pre_rst.idle");
    set_write(5);
    step("rst.wr");
    set_idle();
    step("rst.idle");
    set_read1(5);
    step("rst.stall");
    check("rst.pre_stall", 32'(last_stall), 1);
    #2;
    rst = 0;
    model_reset();
    #1;
    check("rst.async.busy_mask", busy_mask, 0);
    check("rst.async.dec_ready", 32'(dec_ready), 1);
    check("rst.async.stall", 32'(stall), 0);
    check("rst.async.stall_start", 32'(stall_start), 0);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    step("rst.after");
    step("rst.after2");
    check("rst.no_start", 32'(last_start), 0);

`ifdef HAZARD_STALL_CNT_EN
    set_idle();
    do_reset();
    run_dep(0, "cnt1", n, starts);
    run_dep(0, "cnt2", n, starts);
    check("cnt.two_stalls", 32'(stall_cycles), 6);
    set_read1(5);
    force dut.hazard = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    release dut.hazard;
    set_idle();
    #1;
    check("cnt.saturate", 32'(stall_cycles), 32'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
